video_gen_window: RTL and testbench

- Parametrised pixel generator between the VGA timing controller and the image RAM.
- Maps a screen coordinate onto a placeable, optionally 2x-scaled image window and issues a read to a synchronous RAM with configurable latency.
- Converts the returned byte to RGB888 in grayscale, RGB332, test-pattern or solid mode.
- Delays hsync/vsync/blank through the pipeline so the pixels stay aligned with sync.

---
 rtl/video_gen_window_if.sv | 11 +
 rtl/video_gen_window.sv | 166 ++++++++++++++++
 tb/tb_video_gen_window.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/video_gen_window_if.sv
// Image RAM read port between the pixel generator and its RAM.
// Address goes out, read data comes back a fixed latency later.
interface video_gen_window_if #(
  parameter int ADDR_W = 16
) ();
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_q;

  modport master (output mem_addr, input mem_q);
  modport slave  (input mem_addr, output mem_q);
endinterface

// File: rtl/video_gen_window.sv
// Windowed image pixel generator: screen coord -> RAM read -> RGB888.
// Sync and blank ride along so pixels stay aligned with them.
module video_gen_window #(
  parameter int IMG_W   = 256,
  parameter int IMG_H   = 256,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               blank_in,
  input  logic               hsync_in,
  input  logic               vsync_in,
  input  logic [COORD_W-1:0] win_x0,
  input  logic [COORD_W-1:0] win_y0,
  input  logic               scale2x,
  input  logic [1:0]         mode,
  input  logic [23:0]        border,
  video_gen_window_if.master mem,
  output logic [7:0]         r,
  output logic [7:0]         g,
  output logic [7:0]         b,
  output logic               hsync_out,
  output logic               vsync_out
);

  localparam int BAR_W = (IMG_W / 8 < 1) ? 1 : IMG_W / 8;
  localparam logic [COORD_W-1:0] BAR_C = COORD_W'(BAR_W);
  localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

  typedef struct packed {
    logic               in_win;
    logic [1:0]         mode;
    logic [23:0]        border;
    logic [COORD_W-1:0] col;
    logic               hs;
    logic               vs;
    logic               bl;
  } side_t;

  // Blank set on reset so the output shows black until real data arrives
  localparam side_t SIDE_RST = '{
    in_win: 1'b0, mode: 2'b00, border: 24'h0, col: '0,
    hs: 1'b0, vs: 1'b0, bl: 1'b1
  };

  side_t               s0_d, s0_q;
  logic [COORD_W-1:0]  dy0_d, dy0_q;
  logic                sc0_d, sc0_q;
  side_t               s1_d, s1_q;
  logic [ADDR_W-1:0]   addr_d, addr_q;
  side_t               dl_d [MEM_LAT];
  side_t               dl_q [MEM_LAT];
  logic [23:0]         rgb_d, rgb_q;
  logic                hs_d, hs_q;
  logic                vs_d, vs_q;

  logic [COORD_W:0]    dx, dy;
  logic [31:0]         lim_x, lim_y;
  logic [COORD_W-1:0]  colv, rowv;
  logic [COORD_W-1:0]  idx;
  logic [2:0]          bar;
  side_t               o;
  logic [7:0]          q;

  // Stage 0: window-relative offsets and the in-window test
  always_comb begin
    dx    = {1'b0, x} - {1'b0, win_x0};
    dy    = {1'b0, y} - {1'b0, win_y0};
    lim_x = scale2x ? 32'(IMG_W) << 1 : 32'(IMG_W);
    lim_y = scale2x ? 32'(IMG_H) << 1 : 32'(IMG_H);
    s0_d        = SIDE_RST;
    s0_d.in_win = !blank_in && !dx[COORD_W] && !dy[COORD_W]
                  && (32'(dx[COORD_W-1:0]) < lim_x)
                  && (32'(dy[COORD_W-1:0]) < lim_y);
    s0_d.mode   = mode;
    s0_d.border = border;
    s0_d.col    = dx[COORD_W-1:0];
    s0_d.hs     = hsync_in;
    s0_d.vs     = vsync_in;
    s0_d.bl     = blank_in;
    dy0_d       = dy[COORD_W-1:0];
    sc0_d       = scale2x;
  end

  // Stage 1: image address; held outside the window to avoid read toggling
  always_comb begin
    colv     = s0_q.col >> sc0_q;
    rowv     = dy0_q >> sc0_q;
    s1_d     = s0_q;
    s1_d.col = colv;
    addr_d   = addr_q;
    if (s0_q.in_win)
      addr_d = ADDR_W'(colv) + ADDR_W'(rowv) * IMG_W_A;
  end

  // Sideband delay line matching the RAM read latency
  always_comb begin
    dl_d[0] = s1_q;
    for (int i = 1; i < MEM_LAT; i++)
      dl_d[i] = dl_q[i-1];
  end

  // Output stage: colour conversion against the returned RAM byte
  always_comb begin
    o     = dl_q[MEM_LAT-1];
    q     = mem.mem_q;
    idx   = o.col / BAR_C;
    bar   = (idx > COORD_W'(7)) ? 3'd7 : idx[2:0];
    rgb_d = 24'h0;
    hs_d  = o.hs;
    vs_d  = o.vs;
    if (o.bl) begin
      rgb_d = 24'h0;
    end else if (!o.in_win) begin
      rgb_d = o.border;
    end else begin
      unique case (o.mode)
        2'b00: rgb_d = {q, q, q};
        2'b01: rgb_d = {q[7:5], q[7:5], q[7:6],
                        q[4:2], q[4:2], q[4:3],
                        q[1:0], q[1:0], q[1:0], q[1:0]};
        2'b10: rgb_d = {{8{bar[2]}}, {8{bar[1]}}, {8{bar[0]}}};
        2'b11: rgb_d = o.border;
      endcase
    end
  end

  // Pipeline registers, all cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_q   <= SIDE_RST;
      dy0_q  <= '0;
      sc0_q  <= 1'b0;
      s1_q   <= SIDE_RST;
      addr_q <= '0;
      for (int i = 0; i < MEM_LAT; i++)
        dl_q[i] <= SIDE_RST;
      rgb_q  <= 24'h0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
    end else begin
      s0_q   <= s0_d;
      dy0_q  <= dy0_d;
      sc0_q  <= sc0_d;
      s1_q   <= s1_d;
      addr_q <= addr_d;
      for (int i = 0; i < MEM_LAT; i++)
        dl_q[i] <= dl_d[i];
      rgb_q  <= rgb_d;
      hs_q   <= hs_d;
      vs_q   <= vs_d;
    end
  end

  assign mem.mem_addr = addr_q;
  assign r            = rgb_q[23:16];
  assign g            = rgb_q[15:8];
  assign b            = rgb_q[7:0];
  assign hsync_out    = hs_q;
  assign vsync_out    = vs_q;

endmodule

// File: tb/tb_video_gen_window.sv
// Directed bench for video_gen_window: one build at MEM_LAT=1,
// one at MEM_LAT=3, each with a RAM model returning addr[7:0].
module tb_video_gen_window;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [9:0]  x = '0, y = '0, win_x0 = '0, win_y0 = '0;
  logic        blank_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
  logic        scale2x = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [23:0] border = 24'h123456;

  logic [7:0]  r1, g1, b1, r3, g3, b3;
  logic        hs1, vs1, hs3, vs3;
  logic [23:0] rgb1, rgb3;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  video_gen_window_if #(.ADDR_W(16)) m1 ();
  video_gen_window_if #(.ADDR_W(16)) m3 ();

  video_gen_window dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .win_x0(win_x0), .win_y0(win_y0), .scale2x(scale2x),
    .mode(mode), .border(border), .mem(m1),
    .r(r1), .g(g1), .b(b1), .hsync_out(hs1), .vsync_out(vs1)
  );

  video_gen_window #(.MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y),
    .blank_in(blank_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .win_x0(win_x0), .win_y0(win_y0), .scale2x(scale2x),
    .mode(mode), .border(border), .mem(m3),
    .r(r3), .g(g3), .b(b3), .hsync_out(hs3), .vsync_out(vs3)
  );

  assign rgb1 = {r1, g1, b1};
  assign rgb3 = {r3, g3, b3};

  // RAM models: RAM[a] = a[7:0]
  logic [7:0] q1 = 8'h0;
  logic [7:0] q3a = 8'h0, q3b = 8'h0, q3c = 8'h0;
  always @(posedge clk) begin
    q1  <= m1.mem_addr[7:0];
    q3a <= m3.mem_addr[7:0];
    q3b <= q3a;
    q3c <= q3b;
  end
  assign m1.mem_q = q1;
  assign m3.mem_q = q3c;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [9:0] wx, input logic [9:0] wy,
                     input logic sc, input logic [1:0] md);
    win_x0 = wx; win_y0 = wy; scale2x = sc; mode = md;
    y = 10'd0; blank_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #3;
    checks++; if (rgb1 !== 24'h0) begin failures++;
      $display("FAIL reset_rgb1 got=%h exp=000000", rgb1); end
    checks++; if (hs1 !== 1'b0 || vs1 !== 1'b0) begin failures++;
      $display("FAIL reset_sync1 got=%b%b exp=00", hs1, vs1); end
    checks++; if (m1.mem_addr !== 16'h0) begin failures++;
      $display("FAIL reset_addr1 got=%h exp=0000", m1.mem_addr); end
    checks++; if (rgb3 !== 24'h0) begin failures++;
      $display("FAIL reset_rgb3 got=%h exp=000000", rgb3); end
    checks++; if (hs3 !== 1'b0 || vs3 !== 1'b0) begin failures++;
      $display("FAIL reset_sync3 got=%b%b exp=00", hs3, vs3); end
    step(); step();
    rst_n = 1'b1;
  endtask

  task automatic test_gray_sweep();
    int ea, k;
    logic [23:0] er;
    cfg(10'd0, 10'd0, 1'b0, 2'b00);
    for (int i = 0; i < 263; i++) begin
      if (i < 260) x = 10'(i);
      step();
      if (i >= 1 && i <= 260) begin
        ea = (i - 1 < 256) ? i - 1 : 255;
        checks++; if (m1.mem_addr !== 16'(ea)) begin failures++;
          $display("FAIL gray_addr x=%0d got=%h exp=%h", i - 1, m1.mem_addr, 16'(ea)); end
      end
      if (i >= 3) begin
        k  = i - 3;
        er = (k < 256) ? {3{8'(k)}} : 24'h123456;
        checks++; if (rgb1 !== er) begin failures++;
          $display("FAIL gray_rgb x=%0d got=%h exp=%h", k, rgb1, er); end
      end
    end
  endtask

  task automatic test_scaled_window();
    int xs [6] = '{99, 100, 101, 102, 611, 612};
    logic [23:0] er [6] = '{24'h123456, 24'h000000, 24'h000000,
                            24'h010101, 24'hffffff, 24'h123456};
    int ea [6] = '{-1, 256, 256, 257, 511, 511};
    cfg(10'd100, 10'd50, 1'b1, 2'b00);
    y = 10'd53;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) x = 10'(xs[i]);
      step();
      if (i >= 1 && i <= 6 && ea[i-1] >= 0) begin
        checks++; if (m1.mem_addr !== 16'(ea[i-1])) begin failures++;
          $display("FAIL scaled_addr x=%0d got=%h exp=%h", xs[i-1], m1.mem_addr, 16'(ea[i-1])); end
      end
      if (i >= 3) begin
        checks++; if (rgb1 !== er[i-3]) begin failures++;
          $display("FAIL scaled_rgb x=%0d got=%h exp=%h", xs[i-3], rgb1, er[i-3]); end
      end
    end
  endtask

  task automatic test_rgb332();
    int xs [2] = '{227, 146};
    logic [23:0] er [2] = '{24'hff00ff, 24'h9292aa};
    cfg(10'd0, 10'd0, 1'b0, 2'b01);
    for (int i = 0; i < 5; i++) begin
      if (i < 2) x = 10'(xs[i]);
      step();
      if (i >= 3) begin
        checks++; if (rgb1 !== er[i-3]) begin failures++;
          $display("FAIL rgb332 x=%0d got=%h exp=%h", xs[i-3], rgb1, er[i-3]); end
      end
    end
  endtask

  task automatic test_bars();
    int xs [8] = '{0, 31, 32, 63, 64, 224, 255, 256};
    logic [23:0] er [8] = '{24'h000000, 24'h000000, 24'h0000ff, 24'h0000ff,
                            24'h00ff00, 24'hffffff, 24'hffffff, 24'h123456};
    cfg(10'd0, 10'd0, 1'b0, 2'b10);
    for (int i = 0; i < 11; i++) begin
      if (i < 8) x = 10'(xs[i]);
      step();
      if (i >= 3) begin
        checks++; if (rgb1 !== er[i-3]) begin failures++;
          $display("FAIL bars x=%0d got=%h exp=%h", xs[i-3], rgb1, er[i-3]); end
      end
    end
  endtask

  task automatic test_lat3();
    int xs [4] = '{5, 6, 7, 8};
    logic hs [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    logic vs [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic bl [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [23:0] er [4] = '{24'h050505, 24'h060606, 24'h000000, 24'h080808};
    cfg(10'd0, 10'd0, 1'b0, 2'b00);
    for (int i = 0; i < 9; i++) begin
      if (i < 4) begin
        x = 10'(xs[i]); hsync_in = hs[i]; vsync_in = vs[i]; blank_in = bl[i];
      end else begin
        hsync_in = 1'b0; vsync_in = 1'b0; blank_in = 1'b0;
      end
      step();
      if (i >= 5) begin
        checks++; if (hs3 !== hs[i-5] || vs3 !== vs[i-5]) begin failures++;
          $display("FAIL lat3_sync v=%0d got=%b%b exp=%b%b", i - 5, hs3, vs3, hs[i-5], vs[i-5]); end
        checks++; if (rgb3 !== er[i-5]) begin failures++;
          $display("FAIL lat3_rgb v=%0d got=%h exp=%h", i - 5, rgb3, er[i-5]); end
      end
    end
  endtask

  task automatic test_reset_midline();
    logic [23:0] er;
    cfg(10'd0, 10'd0, 1'b0, 2'b00);
    for (int i = 0; i < 6; i++) begin
      x = 10'(10 + i);
      step();
      if (i >= 3) begin
        er = {3{8'(10 + i - 3)}};
        checks++; if (rgb1 !== er) begin failures++;
          $display("FAIL pre_reset_rgb i=%0d got=%h exp=%h", i, rgb1, er); end
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (rgb1 !== 24'h0) begin failures++;
      $display("FAIL async_reset_rgb got=%h exp=000000", rgb1); end
    checks++; if (m1.mem_addr !== 16'h0) begin failures++;
      $display("FAIL async_reset_addr got=%h exp=0000", m1.mem_addr); end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      x = 10'(50 + i);
      step();
      er = (i < 3) ? 24'h0 : {3{8'(50 + i - 3)}};
      checks++; if (rgb1 !== er) begin failures++;
        $display("FAIL post_reset_rgb i=%0d got=%h exp=%h", i, rgb1, er); end
    end
  endtask

  initial begin
    test_reset();
    test_gray_sweep();
    test_scaled_window();
    test_rgb332();
    test_bars();
    test_lat3();
    test_reset_midline();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
